// File: rtl/matrix_mac_sequencer_if.sv
// Result stream of the matrix MAC sequencer: one C element per valid/ready
// handshake, in row-major order, tagged with its row/column index.
//   master: res_valid, res_data, res_row, res_col out; res_ready in
//   slave : the mirror image, used by the result sink
interface matrix_mac_sequencer_if #(
  parameter int unsigned ACC_WIDTH = 18,
  parameter int unsigned IDX_WIDTH = 2
) ();
  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_WIDTH-1:0] res_data;
  logic [IDX_WIDTH-1:0] res_row;
  logic [IDX_WIDTH-1:0] res_col;

  modport master (
    output res_valid, res_data, res_row, res_col,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_data, res_row, res_col,
    output res_ready
  );
endinterface

// File: rtl/matrix_mac_sequencer.sv
// Sequencer for C = A x B on DIMxDIM matrices using a shared MAC unit.
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   start, abort        request a multiply (IDLE only) / cancel to IDLE
//   busy, done          not-IDLE flag / pulse after the last result handshake
//   rd_en, a_addr,      operand memory reads (data returned one cycle later)
//   b_addr
//   mac_enable,         MAC strobes, rd_en delayed by one cycle;
//   mac_clear           clear marks the k=0 product of each element
//   mac_result          MAC accumulator, captured after the drain window
//   res                 result stream (valid/ready, data, row, col)
module matrix_mac_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM        = 4,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(DIM),
  parameter int unsigned ADDR_WIDTH = $clog2(DIM * DIM)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  mac_enable,
  output logic                  mac_clear,
  input  logic [ACC_WIDTH-1:0]  mac_result,
  matrix_mac_sequencer_if.master res
);

  localparam int unsigned IDX_WIDTH = $clog2(DIM);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DIM - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic                  d_q, d_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_en_q, rd_en_d;
  logic                  mac_enable_q, mac_enable_d;
  logic                  mac_clear_q, mac_clear_d;
  logic                  res_valid_q, res_valid_d;
  logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      i_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      d_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      mac_enable_q <= 1'b0;
      mac_clear_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      k_q          <= k_d;
      d_q          <= d_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      mac_enable_q <= mac_enable_d;
      mac_clear_q  <= mac_clear_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
    end
  end

  // Next-state, counter and output-register logic
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    k_d          = k_q;
    d_d          = d_q;
    done_d       = 1'b0;
    res_data_d   = res_data_q;
    // MAC strobes trail the read strobe by the memory latency
    mac_enable_d = rd_en_q;
    mac_clear_d  = rd_en_q && (k_q == '0);

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ISSUE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        k_d = k_q + IDX_WIDTH'(1);
        if (k_q == LAST_IDX) begin
          state_d = DRAIN;
          d_d     = 1'b0;
        end
      end
      DRAIN: begin
        // Second drain cycle: last accumulate is now visible on mac_result
        d_d = 1'b1;
        if (d_q) begin
          state_d    = OUTPUT;
          res_data_d = mac_result;
        end
      end
      OUTPUT: begin
        if (res.res_ready) begin
          j_d = j_q + IDX_WIDTH'(1);
          if (j_q == LAST_IDX) begin
            i_d = i_q + IDX_WIDTH'(1);
          end
          if ((i_q == LAST_IDX) && (j_q == LAST_IDX)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            k_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything and flushes the in-flight MAC strobe
    if (abort) begin
      state_d      = IDLE;
      i_d          = '0;
      j_d          = '0;
      k_d          = '0;
      d_d          = 1'b0;
      done_d       = 1'b0;
      mac_enable_d = 1'b0;
      mac_clear_d  = 1'b0;
    end

    busy_d      = (state_d != IDLE);
    rd_en_d     = (state_d == ISSUE);
    res_valid_d = (state_d == OUTPUT);
  end

  // DIM is a power of two, so i*DIM+k is a plain concatenation
  assign a_addr     = ADDR_WIDTH'({i_q, k_q});
  assign b_addr     = ADDR_WIDTH'({k_q, j_q});
  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_en      = rd_en_q;
  assign mac_enable = mac_enable_q;
  assign mac_clear  = mac_clear_q;

  assign res.res_valid = res_valid_q;
  assign res.res_data  = res_data_q;
  assign res.res_row   = i_q;
  assign res.res_col   = j_q;

endmodule

// File: doc/matrix_mac_sequencer.md
# matrix_mac_sequencer

Sequencer that drives a shared `matrix_mac_unit` to compute C = A × B for DIM×DIM operand matrices held in two synchronous-read operand memories. It generates row/column read addresses, times the MAC `enable`/`clear` strobes against the memory read latency, and captures each accumulated dot product. Each C element is presented on a valid/ready result stream in row-major order. It sits between the operand buffers and the result sink, and it is the only master of the MAC unit's control inputs.

## Interface
- `DATA_WIDTH`, 8, operand element width.
- `DIM`, 4, matrix dimension; legal values are ≥2 and a power of two.
- `ACC_WIDTH`, 2*DATA_WIDTH+$clog2(DIM), width of MAC result and `res_data`.
- `ADDR_WIDTH`, $clog2(DIM*DIM), operand memory address width.

Ports:
- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request a full multiply; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result handshake.
- `rd_en`  out  1  operand memory read strobe; data is returned one cycle later.
- `a_addr`  out  ADDR_WIDTH  A address = i*DIM+k.
- `b_addr`  out  ADDR_WIDTH  B address = k*DIM+j.
- `mac_enable`  out  1  MAC `enable`; equals `rd_en` delayed by one cycle.
- `mac_clear`  out  1  MAC `clear`; high together with the first `mac_enable` of each element (k=0). MAC then loads the product instead of accumulating.
- `mac_result`  in  ACC_WIDTH  MAC accumulator; updates one cycle after each enable.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  sink accepts the result.
- `res_data`  out  ACC_WIDTH  captured C[i][j].
- `res_row`, `res_col`  out  $clog2(DIM) each  index of the current result.

## Operation
- States: IDLE, ISSUE, DRAIN, OUTPUT.
- Element counters i (row), j (col); product counter k; drain counter d (1 bit).
- IDLE → ISSUE when `start`=1. On entry, i=j=k=0.
- ISSUE: `rd_en`=1 with the addresses above, and k increments each cycle. After the cycle with k=DIM-1, go to DRAIN with d=0.
- DRAIN: held for 2 cycles. At the end of the second cycle, `mac_result` is registered into `res_data` and the state moves to OUTPUT.
- OUTPUT: `res_valid`=1, and `res_data`/`res_row`/`res_col` are held stable until the handshake (`res_valid`&`res_ready`). On handshake:
  - j increments; when j wraps, i increments.
  - If the element was (DIM-1, DIM-1), go to IDLE and pulse `done`.
  - Otherwise go to ISSUE with k=0.
- `start` is ignored when not in IDLE. `start` and `abort` asserted together in IDLE: `abort` wins and the state stays IDLE.
- `abort` in any non-IDLE state:
  - Next state is IDLE with counters cleared.
  - The pending delayed `mac_enable` is flushed, so `mac_enable` is 0 in the next cycle.
  - `res_valid` drops and `done` is not pulsed.
- Arithmetic: the sequencer does not modify the data; `res_data` is `mac_result` bit for bit. Overflow cannot occur given ACC_WIDTH.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `rd_en`, `mac_enable`, `mac_clear`, `res_valid` = 0; `a_addr`, `b_addr`, `res_data`, `res_row`, `res_col` = 0.
- Cycle 0 is the cycle in which `start` is sampled high. For each element starting at cycle s:
  - `rd_en` is high in cycles s..s+DIM-1.
  - `mac_enable` is high in cycles s+1..s+DIM; `mac_clear` is high in cycle s+1.
  - DRAIN occupies cycles s+DIM and s+DIM+1.
  - `res_valid` first rises in cycle s+DIM+2.
- First element: s=1. With `res_ready` held high, the element period is DIM+3 cycles. Each cycle of `res_ready`=0 adds one stall cycle.
- DIM=4, `res_ready`=1: handshakes occur in cycles 7, 14, …, 112; `done`=1 and `busy`=0 in cycle 113. A new `start` is accepted in cycle 113.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously). After release, the block is in IDLE.

## Test plan
- Reset check: assert `reset` with `start`=1 → all outputs at reset values, and `busy` stays 0 while `reset` is high.
- DIM=4, A=identity, B[r][c]=r*4+c, `res_ready`=1 → 16 results equal to B in row-major order with correct `res_row`/`res_col`. Handshakes in cycles 7+7n; `done` in cycle 113 only.
- All-255 operands, DIM=4, DATA_WIDTH=8 → every `res_data`=260100 (4·255²), with no truncation. `mac_clear` is high exactly once per element.
- Backpressure: `res_ready`=0 for 5 cycles on element (1,2) → `res_valid` stays high, data/indices stay stable, no new `rd_en`. Total run extends by 5 cycles.
- `abort` in cycle 3 (mid-ISSUE) → IDLE in cycle 4, `mac_enable`=0 in cycle 4, no `done`. A following `start` produces a correct full result set.
- `start` pulsed while busy, and `start`+`abort` together in IDLE → both ignored; the result sequence and `done` timing are unchanged.
